// File: rtl/apb_bridge_ctrl_if.sv
// APB slave bus bundle for the APB-to-AXI-lite bridge transaction controller.
interface apb_bridge_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   s_apb_paddr;
   logic                    s_apb_psel;
   logic                    s_apb_penable;
   logic                    s_apb_pwrite;
   logic [DATA_WIDTH-1:0]   s_apb_pwdata;
   logic [DATA_WIDTH/8-1:0] s_apb_pstrb;
   logic [DATA_WIDTH-1:0]   s_apb_prdata;
   logic                    s_apb_pready;
   logic                    s_apb_pslverr;

   modport slave (
      input  s_apb_paddr, s_apb_psel, s_apb_penable, s_apb_pwrite, s_apb_pwdata, s_apb_pstrb,
      output s_apb_prdata, s_apb_pready, s_apb_pslverr
   );

   modport master (
      output s_apb_paddr, s_apb_psel, s_apb_penable, s_apb_pwrite, s_apb_pwdata, s_apb_pstrb,
      input  s_apb_prdata, s_apb_pready, s_apb_pslverr
   );
endinterface

// File: rtl/apb_bridge_ctrl.sv
// APB-side transaction controller: captures APB requests, fires one start pulse
// toward the CDC synchronisers, waits for the matching response and completes APB.
module apb_bridge_ctrl #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned MIN_GAP        = 4
) (
   input  logic                    apb_clk,
   input  logic                    sys_aresetn,
   apb_bridge_ctrl_if.slave        apb,
   output logic                    apb_cd_start_read,
   output logic                    apb_cd_start_write,
   input  logic                    apb_cd_read_data_valid,
   input  logic                    apb_cd_done_write,
   output logic [ADDR_WIDTH-1:0]   cmd_addr,
   output logic [DATA_WIDTH-1:0]   cmd_wdata,
   output logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   input  logic [DATA_WIDTH-1:0]   rsp_rdata,
   input  logic                    rsp_err,
   output logic                    busy,
   output logic                    stray_rsp
);
   localparam int unsigned STRB_W  = DATA_WIDTH / 8;
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned GAP_W   = $clog2(MIN_GAP);
   localparam int unsigned CNT_RAW = (TO_W > GAP_W) ? TO_W : GAP_W;
   localparam int unsigned CNT_W   = (CNT_RAW == 0) ? 1 : CNT_RAW;
   localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_RESP  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   logic [2:0]            r_state,       w_state;
   logic [CNT_W-1:0]      r_cnt,         w_cnt;
   logic                  r_is_write,    w_is_write;
   logic                  r_start_read,  w_start_read;
   logic                  r_start_write, w_start_write;
   logic                  r_pready,      w_pready;
   logic [DATA_WIDTH-1:0] r_prdata,      w_prdata;
   logic                  r_pslverr,     w_pslverr;
   logic                  r_stray,       w_stray;
   logic                  r_busy,        w_busy;
   logic [ADDR_WIDTH-1:0] r_cmd_addr,    w_cmd_addr;
   logic [DATA_WIDTH-1:0] r_cmd_wdata,   w_cmd_wdata;
   logic [STRB_W-1:0]     r_cmd_wstrb,   w_cmd_wstrb;
   logic                  w_match;
   logic                  w_unused_penable;

   // Capture happens in the setup phase, so penable carries no information here.
   assign w_unused_penable = apb.s_apb_penable;

   always_ff @(posedge apb_clk or negedge sys_aresetn) begin
      if (!sys_aresetn) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_is_write    <= 1'b0;
         r_start_read  <= 1'b0;
         r_start_write <= 1'b0;
         r_pready      <= 1'b0;
         r_prdata      <= '0;
         r_pslverr     <= 1'b0;
         r_stray       <= 1'b0;
         r_busy        <= 1'b0;
         r_cmd_addr    <= '0;
         r_cmd_wdata   <= '0;
         r_cmd_wstrb   <= '0;
      end else begin
         r_state       <= w_state;
         r_cnt         <= w_cnt;
         r_is_write    <= w_is_write;
         r_start_read  <= w_start_read;
         r_start_write <= w_start_write;
         r_pready      <= w_pready;
         r_prdata      <= w_prdata;
         r_pslverr     <= w_pslverr;
         r_stray       <= w_stray;
         r_busy        <= w_busy;
         r_cmd_addr    <= w_cmd_addr;
         r_cmd_wdata   <= w_cmd_wdata;
         r_cmd_wstrb   <= w_cmd_wstrb;
      end
   end

   always_comb begin
      w_state       = r_state;
      w_cnt         = r_cnt;
      w_is_write    = r_is_write;
      w_cmd_addr    = r_cmd_addr;
      w_cmd_wdata   = r_cmd_wdata;
      w_cmd_wstrb   = r_cmd_wstrb;
      w_start_read  = 1'b0;
      w_start_write = 1'b0;
      w_pready      = 1'b0;
      w_prdata      = '0;
      w_pslverr     = 1'b0;
      w_match       = r_is_write ? apb_cd_done_write : apb_cd_read_data_valid;
      w_stray       = apb_cd_read_data_valid | apb_cd_done_write;

      case (r_state)
         ST_IDLE: begin
            if (apb.s_apb_psel) begin
               w_is_write    = apb.s_apb_pwrite;
               w_cmd_addr    = apb.s_apb_paddr;
               w_cmd_wdata   = apb.s_apb_pwrite ? apb.s_apb_pwdata : '0;
               w_cmd_wstrb   = apb.s_apb_pwrite ? apb.s_apb_pstrb  : '0;
               w_start_read  = ~apb.s_apb_pwrite;
               w_start_write = apb.s_apb_pwrite;
               w_state       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_cnt   = CNT_W'(TIMEOUT_CYCLES);
            w_state = ST_WAIT;
         end
         ST_WAIT: begin
            // Only the pulse of the other direction is stray while waiting.
            w_stray = r_is_write ? apb_cd_read_data_valid : apb_cd_done_write;
            if (w_match) begin
               w_pready  = 1'b1;
               w_prdata  = r_is_write ? '0 : rsp_rdata;
               w_pslverr = rsp_err;
               w_state   = ST_RESP;
            end else if (TO_EN && (r_cnt == CNT_W'(1))) begin
               w_pready  = 1'b1;
               w_pslverr = 1'b1;
               w_state   = ST_RESP;
            end else if (TO_EN) begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            w_cnt   = CNT_W'(MIN_GAP - 1);
            w_state = ST_GAP;
         end
         ST_GAP: begin
            if (r_cnt == '0) begin
               w_state = ST_IDLE;
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state = ST_IDLE;
      endcase

      w_busy = (w_state != ST_IDLE);
   end

   assign apb.s_apb_prdata  = r_prdata;
   assign apb.s_apb_pready  = r_pready;
   assign apb.s_apb_pslverr = r_pslverr;
   assign apb_cd_start_read  = r_start_read;
   assign apb_cd_start_write = r_start_write;
   assign cmd_addr  = r_cmd_addr;
   assign cmd_wdata = r_cmd_wdata;
   assign cmd_wstrb = r_cmd_wstrb;
   assign busy      = r_busy;
   assign stray_rsp = r_stray;
endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Bench for apb_bridge_ctrl: directed scenarios plus random APB traffic, checked
// every cycle against a timestamp/window model of the controller.
module tb_apb_bridge_ctrl;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = 4;
   localparam int          TO  = 8;
   localparam int          GAP = 4;

   logic          apb_clk = 1'b0;
   logic          sys_aresetn = 1'b0;
   logic          apb_cd_start_read, apb_cd_start_write;
   logic          apb_cd_read_data_valid = 1'b0;
   logic          apb_cd_done_write = 1'b0;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_wstrb;
   logic [DW-1:0] rsp_rdata = '0;
   logic          rsp_err = 1'b0;
   logic          busy, stray_rsp;

   int n_vec = 0;
   int n_mis = 0;
   int cyc   = 0;

   apb_bridge_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_apb ();

   apb_bridge_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .MIN_GAP(GAP)
   ) dut (
      .apb_clk(apb_clk), .sys_aresetn(sys_aresetn), .apb(u_apb),
      .apb_cd_start_read(apb_cd_start_read), .apb_cd_start_write(apb_cd_start_write),
      .apb_cd_read_data_valid(apb_cd_read_data_valid), .apb_cd_done_write(apb_cd_done_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .stray_rsp(stray_rsp)
   );

   always #5 apb_clk = ~apb_clk;

   task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string name);
      n_vec++;
      n_mis++;
      $display("FAIL %s: bound expired waiting on DUT (cycle %0d)", name, cyc);
   endtask

   // Model: a transaction owns a response window [m_lo, m_hi]; after it resolves at
   // cycle k the controller is busy until cycle k+2+GAP.
   bit            m_inflight = 0, m_write = 0;
   int            m_lo = 0, m_hi = 0, m_free = 0, k = 0;
   bit            rd_in, wr_in, rd_used, wr_used;
   logic          e_start_rd = 0, e_start_wr = 0, e_pready = 0, e_pslverr = 0;
   logic          e_stray = 0, e_busy = 0;
   logic [DW-1:0] e_prdata = '0, e_cmd_wdata = '0;
   logic [AW-1:0] e_cmd_addr = '0;
   logic [SW-1:0] e_cmd_wstrb = '0;

   always @(posedge apb_clk or negedge sys_aresetn) begin
      if (!sys_aresetn) begin
         m_inflight = 0; m_free = 0;
         e_start_rd = 0; e_start_wr = 0; e_pready = 0; e_pslverr = 0; e_prdata = '0;
         e_stray = 0; e_busy = 0; e_cmd_addr = '0; e_cmd_wdata = '0; e_cmd_wstrb = '0;
      end else begin
         k = cyc;
         rd_in = apb_cd_read_data_valid; wr_in = apb_cd_done_write;
         rd_used = 0; wr_used = 0;
         e_start_rd = 0; e_start_wr = 0; e_pready = 0; e_prdata = '0; e_pslverr = 0;
         if (m_inflight && k >= m_lo) begin
            if (m_write ? wr_in : rd_in) begin
               e_pready = 1; e_pslverr = rsp_err;
               e_prdata = m_write ? '0 : rsp_rdata;
               if (m_write) wr_used = 1; else rd_used = 1;
               m_inflight = 0; m_free = k + 2 + GAP;
            end else if (TO != 0 && k >= m_hi) begin
               e_pready = 1; e_pslverr = 1;
               m_inflight = 0; m_free = k + 2 + GAP;
            end
         end
         e_stray = (rd_in && !rd_used) || (wr_in && !wr_used);
         if (!m_inflight && k >= m_free && u_apb.s_apb_psel) begin
            m_inflight = 1; m_write = u_apb.s_apb_pwrite;
            m_lo = k + 2; m_hi = k + 1 + TO;
            e_cmd_addr  = u_apb.s_apb_paddr;
            e_cmd_wdata = m_write ? u_apb.s_apb_pwdata : '0;
            e_cmd_wstrb = m_write ? u_apb.s_apb_pstrb : '0;
            if (m_write) e_start_wr = 1; else e_start_rd = 1;
         end
         e_busy = m_inflight || (k + 1 < m_free);
         cyc = cyc + 1;
      end
   end

   always @(negedge apb_clk) begin
      if (sys_aresetn) begin
         chk1("start_read", apb_cd_start_read, e_start_rd);
         chk1("start_write", apb_cd_start_write, e_start_wr);
         chk1("pready", u_apb.s_apb_pready, e_pready);
         chkw("prdata", u_apb.s_apb_prdata, e_prdata);
         chk1("pslverr", u_apb.s_apb_pslverr, e_pslverr);
         chk1("stray_rsp", stray_rsp, e_stray);
         chk1("busy", busy, e_busy);
         chkw("cmd_addr", cmd_addr, e_cmd_addr);
         chkw("cmd_wdata", cmd_wdata, e_cmd_wdata);
         chkw("cmd_wstrb", 32'(cmd_wstrb), 32'(e_cmd_wstrb));
      end
   end

   task automatic set_pulses(input logic rd, input logic wr);
      apb_cd_read_data_valid = rd;
      apb_cd_done_write      = wr;
   endtask

   task automatic wait_start(output bit found);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge apb_clk);
         u_apb.s_apb_penable = 1'b1;
         set_pulses(1'b0, 1'b0);
         if (apb_cd_start_read || apb_cd_start_write) found = 1;
      end
   endtask

   // One APB transfer. d: cycle (after the start pulse) of the matching response,
   // ds: cycle of a pulse of the opposite kind; -1 means none.
   task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [SW-1:0] strb, input int d, input int ds,
                       input logic [DW-1:0] rdata, input logic err, input bit drop,
                       input bit hold, output int s_cyc, output int rdy,
                       output logic [DW-1:0] r_data, output logic r_err);
      bit found;
      s_cyc = -1; rdy = -1; r_data = '0; r_err = 1'b0;
      @(negedge apb_clk);
      set_pulses(1'b0, 1'b0);
      u_apb.s_apb_psel = 1'b1; u_apb.s_apb_penable = 1'b0; u_apb.s_apb_pwrite = wr;
      u_apb.s_apb_paddr = addr; u_apb.s_apb_pwdata = data; u_apb.s_apb_pstrb = strb;
      wait_start(found);
      if (!found) begin
         bound_fail("start_pulse");
         return;
      end
      s_cyc = cyc;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge apb_clk);
         set_pulses(1'b0, 1'b0);
         rsp_rdata = $urandom; rsp_err = 1'($urandom_range(0, 1));
         if (rdy < 0 && u_apb.s_apb_pready) begin
            rdy = c; r_data = u_apb.s_apb_prdata; r_err = u_apb.s_apb_pslverr;
         end
         if ((rdy >= 0 && c > rdy && !hold) || (drop && c == 1)) begin
            u_apb.s_apb_psel = 1'b0; u_apb.s_apb_penable = 1'b0;
         end
         if (c == d) begin
            if (wr) apb_cd_done_write = 1'b1; else apb_cd_read_data_valid = 1'b1;
            rsp_rdata = rdata; rsp_err = err;
         end
         if (c == ds) begin
            if (wr) apb_cd_read_data_valid = 1'b1; else apb_cd_done_write = 1'b1;
         end
         if (rdy >= 0 && c > d && c > ds) break;
      end
      if (rdy < 0) begin
         set_pulses(1'b0, 1'b0);
         bound_fail("pready");
      end
   endtask

   task automatic idle(input int n, input bit noise);
      for (int i = 0; i < n; i++) begin
         @(negedge apb_clk);
         u_apb.s_apb_psel = 1'b0; u_apb.s_apb_penable = 1'b0;
         set_pulses(1'b0, 1'b0);
         rsp_rdata = $urandom;
         if (noise && $urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 1) apb_cd_read_data_valid = 1'b1;
            else apb_cd_done_write = 1'b1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before the bench finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int            sa, sb, rdy;
      logic [DW-1:0] rd;
      logic          re;
      bit            found;
      u_apb.s_apb_psel = 0; u_apb.s_apb_penable = 0; u_apb.s_apb_pwrite = 0;
      u_apb.s_apb_paddr = '0; u_apb.s_apb_pwdata = '0; u_apb.s_apb_pstrb = '0;

      #12;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_pready", u_apb.s_apb_pready, 1'b0);
      chkw("rst_cmd_addr", cmd_addr, 32'h0);
      #10 sys_aresetn = 1'b1;
      idle(3, 0);

      xfer(0, 32'h10, 32'h5555_AAAA, 4'hF, 5, -1, 32'hDEAD_BEEF, 0, 0, 0, sa, rdy, rd, re);
      chkw("rd_latency", 32'(rdy), 32'd6);
      chkw("rd_prdata", rd, 32'hDEAD_BEEF);
      chk1("rd_pslverr", re, 1'b0);
      chkw("rd_cmd_wstrb", 32'(cmd_wstrb), 32'h0);
      idle(2, 0);

      xfer(1, 32'h20, 32'h1234_5678, 4'hF, 3, -1, 32'hFFFF_FFFF, 1, 0, 0, sa, rdy, rd, re);
      chkw("wr_latency", 32'(rdy), 32'd4);
      chkw("wr_prdata", rd, 32'h0);
      chk1("wr_pslverr", re, 1'b1);
      chkw("wr_cmd_wdata", cmd_wdata, 32'h1234_5678);
      idle(2, 0);

      xfer(0, 32'h30, 32'h0, 4'h0, 10, -1, 32'h1111_2222, 0, 0, 0, sa, rdy, rd, re);
      chkw("to_latency", 32'(rdy), 32'd9);
      chk1("to_pslverr", re, 1'b1);
      chkw("to_prdata", rd, 32'h0);
      chk1("to_late_stray", stray_rsp, 1'b1);
      chk1("to_late_no_pready", u_apb.s_apb_pready, 1'b0);
      idle(6, 0);

      xfer(1, 32'h100, 32'hAAAA_0001, 4'h3, 2, -1, 32'h0, 0, 0, 1, sa, rdy, rd, re);
      sa = sa + rdy;
      xfer(1, 32'h104, 32'hBBBB_0002, 4'hC, 2, -1, 32'h0, 0, 0, 0, sb, rdy, rd, re);
      chkw("b2b_start_spacing", 32'(sb - sa), 32'(GAP + 2));
      chkw("b2b_cmd_addr", cmd_addr, 32'h104);
      idle(6, 0);

      xfer(1, 32'h200, 32'h0BAD_F00D, 4'h5, 8, 4, 32'h0, 0, 0, 0, sa, rdy, rd, re);
      chkw("edge_latency", 32'(rdy), 32'd9);
      chk1("edge_pslverr", re, 1'b0);
      idle(6, 0);

      xfer(0, 32'h300, 32'h0, 4'h0, 3, -1, 32'hCAFE_F00D, 0, 1, 0, sa, rdy, rd, re);
      chkw("drop_latency", 32'(rdy), 32'd4);
      chkw("drop_prdata", rd, 32'hCAFE_F00D);
      idle(6, 0);

      // Reset while a read is waiting for its response.
      @(negedge apb_clk);
      u_apb.s_apb_psel = 1'b1; u_apb.s_apb_penable = 1'b0; u_apb.s_apb_pwrite = 1'b0;
      u_apb.s_apb_paddr = 32'h40;
      wait_start(found);
      if (!found) bound_fail("rst_start_pulse");
      repeat (2) @(negedge apb_clk);
      #2 sys_aresetn = 1'b0;
      #1;
      chk1("arst_busy", busy, 1'b0);
      chk1("arst_pready", u_apb.s_apb_pready, 1'b0);
      chk1("arst_start_read", apb_cd_start_read, 1'b0);
      chkw("arst_cmd_addr", cmd_addr, 32'h0);
      u_apb.s_apb_psel = 1'b0; u_apb.s_apb_penable = 1'b0;
      @(negedge apb_clk);
      #2 sys_aresetn = 1'b1;
      @(negedge apb_clk);
      apb_cd_done_write = 1'b1;
      @(negedge apb_clk);
      apb_cd_done_write = 1'b0;
      chk1("arst_late_stray", stray_rsp, 1'b1);
      chk1("arst_late_no_pready", u_apb.s_apb_pready, 1'b0);
      xfer(0, 32'h44, 32'h0, 4'h0, 2, -1, 32'h7777_8888, 0, 0, 0, sa, rdy, rd, re);
      chkw("post_rst_prdata", rd, 32'h7777_8888);
      idle(2, 0);

      for (int t = 0; t < 80; t++) begin
         bit wr, drop;
         int d, ds;
         wr   = 1'($urandom_range(0, 1));
         drop = ($urandom_range(0, 7) == 0);
         d    = int'($urandom_range(1, TO + 3));
         ds   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TO + 4)) : -1;
         xfer(wr, $urandom, $urandom, 4'($urandom), d, ds, $urandom,
              1'($urandom_range(0, 1)), drop, 0, sa, rdy, rd, re);
         idle(int'($urandom_range(0, 2)), 1);
      end
      idle(8, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule

// File: doc/apb_bridge_ctrl.md
Name: apb_bridge_ctrl

Overview:
- APB-side transaction controller for the APB-to-AXI-lite bridge, in the apb_clk domain.
- Acts as the APB slave: captures each APB request and presents its address, data and strobes as quasi-static command fields.
- Issues a single start pulse toward the clock-domain-crossing pulse synchronisers, then waits for the returned read-data-valid or write-done pulse before completing the APB access.
- Enforces a minimum gap between start pulses (pulse synchronisers cannot accept back-to-back pulses) and a response timeout.

Parameters:
ADDR_WIDTH, 32, APB/command address width
DATA_WIDTH, 32, APB/command data width (multiple of 8)
TIMEOUT_CYCLES, 1024, apb_clk cycles in WAIT before error completion; 0 disables timeout
MIN_GAP, 4, idle apb_clk cycles after each completion before the next capture (>=1)

Ports:
apb_clk  in  1  single clock
sys_aresetn  in  1  asynchronous active-low reset
s_apb_paddr  in  ADDR_WIDTH  APB address
s_apb_psel  in  1  APB select
s_apb_penable  in  1  APB enable
s_apb_pwrite  in  1  1=write, 0=read
s_apb_pwdata  in  DATA_WIDTH  write data
s_apb_pstrb  in  DATA_WIDTH/8  write strobes
s_apb_prdata  out  DATA_WIDTH  read data
s_apb_pready  out  1  transfer complete
s_apb_pslverr  out  1  transfer error
apb_cd_start_read  out  1  one-cycle read start pulse
apb_cd_start_write  out  1  one-cycle write start pulse
apb_cd_read_data_valid  in  1  one-cycle pulse: read response available
apb_cd_done_write  in  1  one-cycle pulse: write response available
cmd_addr  out  ADDR_WIDTH  captured address
cmd_wdata  out  DATA_WIDTH  captured write data
cmd_wstrb  out  DATA_WIDTH/8  captured strobes (all zero for reads)
rsp_rdata  in  DATA_WIDTH  read data, stable when response pulse arrives
rsp_err  in  1  AXI error (SLVERR/DECERR), stable with response pulse
busy  out  1  high in every state except IDLE
stray_rsp  out  1  one-cycle pulse when a response pulse arrives outside WAIT, or a non-matching pulse arrives in WAIT

Behaviour:
- Reset: state=IDLE; all outputs 0, including cmd_* and s_apb_prdata. Reset asserted mid-transaction aborts it with no pulse or pready emitted. Late responses arriving after reset release raise only stray_rsp.
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - When s_apb_psel=1, register paddr/pwdata/pstrb/pwrite, then go to ISSUE.
  - Capture happens whether or not penable is set.
  - Reads capture cmd_wdata=0 and cmd_wstrb=0.
- ISSUE:
  - Assert exactly one of apb_cd_start_read / apb_cd_start_write for one cycle.
  - Load the timeout counter (width $clog2(TIMEOUT_CYCLES+1)) with TIMEOUT_CYCLES.
  - Go to WAIT.
- WAIT:
  - Matching pulse (read_data_valid for a read, done_write for a write): register rsp_rdata (reads only; writes return 0) and rsp_err, then go to RESP.
  - Non-matching pulse: ignored, pulse stray_rsp.
  - Counter decrements each cycle. When it reaches 0 with no matching pulse: prdata=0, pslverr=1, go to RESP.
  - A matching pulse in the same cycle the counter expires wins; the response is taken.
- RESP:
  - s_apb_pready=1 for exactly one cycle, with s_apb_prdata/s_apb_pslverr valid in that cycle.
  - Go to GAP with a counter loaded to MIN_GAP-1.
  - prdata/pslverr are zeroed whenever pready=0.
- GAP: count down, then go to IDLE. Response pulses arriving here pulse stray_rsp.
- cmd_* hold their value from the capture cycle until the next capture; they never change while busy.
- Latency:
  - Setup cycle T: capture.
  - T+1: start pulse.
  - Matching pulse at cycle N: pready at N+1.
  - Minimum back-to-back request spacing is 4+MIN_GAP cycles.
- psel dropped during WAIT (APB protocol violation): the transaction still completes internally and RESP drives pready regardless.
- A new request is only captured in IDLE; psel held through GAP is captured on IDLE entry.

Test Plan:
- Read 0x0000_0010, read_data_valid 5 cycles after start with rsp_rdata=0xDEAD_BEEF, rsp_err=0 -> single start_read pulse; pready one cycle later with prdata=0xDEAD_BEEF, pslverr=0; cmd_wstrb=0.
- Write 0x20 data 0x1234_5678 strb 0xF, done_write with rsp_err=1 -> single start_write pulse; cmd_wdata=0x1234_5678; pready with pslverr=1, prdata=0.
- TIMEOUT_CYCLES=8, read with no response -> pready exactly 9 cycles after start pulse, pslverr=1, prdata=0. A later read_data_valid pulse in GAP/IDLE -> stray_rsp=1 and no extra pready.
- Back-to-back writes, psel held, MIN_GAP=4 -> the two start_write pulses are at least 4 idle cycles apart after the first pready; the second write's cmd_* update only at its capture.
- Write outstanding and done_write pulse coincides with timeout expiry -> response accepted with pslverr=rsp_err. A read_data_valid during the write's WAIT -> stray_rsp, write still waits for done_write.
- sys_aresetn asserted during WAIT -> all outputs 0 immediately. After release, a delayed done_write -> only stray_rsp. A subsequent read completes normally.
